// File: rtl/fixed_acc.sv
// Sign-magnitude fixed-point accumulator: sums a programmed number of product
// beats and presents one saturated sign-magnitude result with a done pulse.
module fixed_acc #(
  parameter int Q     = 16,
  parameter int N     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] len_i,
  input  logic             valid_i,
  input  logic [N-1:0]     data_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [N-1:0]     result_o,
  output logic             sat_o
);

  // Wide enough that 2^CNT_W full-scale magnitudes still fit with a sign bit.
  localparam int ACC_W = N + CNT_W;

  // The fractional point is implicit: inputs and output share the same QN.Q
  // format, so Q only has to be a legal position inside the magnitude.
  if (Q < 0 || Q > N - 1) begin : g_bad_q
    $error("fixed_acc: Q must lie within the magnitude field");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_state_next;
  logic signed [ACC_W-1:0]  r_acc;
  logic signed [ACC_W-1:0]  w_acc_next;
  logic        [CNT_W-1:0]  r_cnt;
  logic        [CNT_W-1:0]  w_cnt_next;
  logic        [N-1:0]      r_result;
  logic                     r_sat;

  logic signed [ACC_W-1:0]  w_mag_in;
  logic signed [ACC_W-1:0]  w_tc;
  logic                     w_load;
  logic                     w_acc_neg;
  logic        [ACC_W-1:0]  w_acc_abs;
  logic                     w_ovf;
  logic        [N-1:0]      w_result_next;

  // Sign-magnitude to two's complement; negative zero maps to 0.
  assign w_mag_in = {{(ACC_W - N + 1){1'b0}}, data_i[N-2:0]};
  assign w_tc     = data_i[N-1] ? -w_mag_in : w_mag_in;

  // NOTE: every always_comb output gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_acc_next   = r_acc;
    w_cnt_next   = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_cnt_next   = len_i;
          w_acc_next   = '0;
          w_state_next = (len_i == '0) ? S_DONE : S_ACC;
        end
      end
      S_ACC: begin
        if (valid_i) begin
          w_acc_next = r_acc + w_tc;
          w_cnt_next = r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            w_state_next = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // The result register loads on the edge that enters DONE, from the value
  // the accumulator takes on that same edge, so it is valid with done_o.
  assign w_load = (w_state_next == S_DONE) && (r_state != S_DONE);

  assign w_acc_neg     = w_acc_next[ACC_W-1];
  assign w_acc_abs     = w_acc_neg ? -w_acc_next : w_acc_next;
  assign w_ovf         = |w_acc_abs[ACC_W-1:N-1];
  assign w_result_next = {w_acc_neg, w_ovf ? {(N-1){1'b1}} : w_acc_abs[N-2:0]};

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_sat    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_acc   <= w_acc_next;
      r_cnt   <= w_cnt_next;
      if (w_load) begin
        r_result <= w_result_next;
        r_sat    <= w_ovf;
      end
    end
  end

  assign busy_o   = (r_state != S_IDLE);
  assign done_o   = (r_state == S_DONE);
  assign result_o = r_result;
  assign sat_o    = r_sat;

endmodule

// File: tb/tb_fixed_acc.sv
// Scoreboard bench for fixed_acc: directed test-plan sums plus randomized
// streams, checked against an integer-arithmetic reference model.
module tb_fixed_acc;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [15:0] len_i;
  logic        valid_i;
  logic [31:0] data_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;
  logic        sat_o;

  fixed_acc #(.Q(16), .N(32), .CNT_W(16)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (start_i),
    .len_i    (len_i),
    .valid_i  (valid_i),
    .data_i   (data_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o),
    .sat_o    (sat_o)
  );

  always #5 clk_i = ~clk_i;

  int          n_checks = 0;
  int          n_errors = 0;
  int          done_count = 0;
  logic [32:0] exp_q[$];      // {sat, result}
  logic [32:0] last_exp = '0;
  logic [31:0] bq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain signed sum of the beats, then saturate to sign-magnitude.
  function automatic logic [32:0] model(input logic [31:0] beats[$]);
    longint sum = 0;
    longint a;
    foreach (beats[i]) begin
      longint m = longint'(beats[i][30:0]);
      sum += beats[i][31] ? -m : m;
    end
    a = (sum < 0) ? -sum : sum;
    if (a > 64'sh7FFF_FFFF) return {1'b1, (sum < 0), 31'h7FFF_FFFF};
    return {1'b0, (sum < 0), a[30:0]};
  endfunction

  // Monitor: pops the scoreboard on every done, otherwise outputs must hold.
  always @(negedge clk_i) begin
    if (rst_i) begin
      last_exp = '0;
    end else if (done_o) begin
      done_count++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check("result", {32'd0, result_o}, {32'd0, e[31:0]});
        check("sat", {63'd0, sat_o}, {63'd0, e[32]});
        last_exp = e;
      end
    end else begin
      check("hold", {31'd0, sat_o, result_o}, {31'd0, last_exp});
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Entered and left #1 after a rising edge with the DUT in IDLE. noise adds a
  // start-cycle beat and stray start pulses in ACC and DONE.
  task automatic run_sum(input int max_gap, input bit noise);
    int n = bq.size();
    exp_q.push_back(model(bq));
    start_i = 1'b1;
    len_i   = 16'(n);
    valid_i = noise;
    data_i  = 32'h0010_0000;
    tick();
    start_i = 1'b0;
    valid_i = 1'b0;
    check("busy_after_start", {63'd0, busy_o}, 64'd1);
    for (int i = 0; i < n; i++) begin
      int gap = $urandom_range(max_gap);
      for (int g = 0; g < gap; g++) begin
        if (noise && $urandom_range(1) == 1) begin
          start_i = 1'b1;
          len_i   = 16'($urandom_range(1, 9));
        end
        tick();
        start_i = 1'b0;
        check("busy_in_gap", {63'd0, busy_o}, 64'd1);
      end
      valid_i = 1'b1;
      data_i  = bq[i];
      tick();
      valid_i = 1'b0;
    end
    check("done_latency", {63'd0, done_o}, 64'd1);
    check("busy_in_done", {63'd0, busy_o}, 64'd1);
    if (noise) begin
      start_i = 1'b1;
      len_i   = 16'd5;
    end
    tick();
    start_i = 1'b0;
    check("idle_done_low", {63'd0, done_o}, 64'd0);
    check("idle_busy_low", {63'd0, busy_o}, 64'd0);
  endtask

  function automatic logic [31:0] rand_beat();
    case ($urandom_range(3))
      0:       return 32'h8000_0000;
      1:       return $urandom;
      default: return {$urandom_range(1) == 1, 11'd0, 20'($urandom)};
    endcase
  endfunction

  initial begin
    int dc;
    rst_i   = 1'b1;
    start_i = 1'b0;
    len_i   = '0;
    valid_i = 1'b0;
    data_i  = '0;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_busy", {63'd0, busy_o}, 64'd0);
    check("rst_done", {63'd0, done_o}, 64'd0);
    check("rst_result", {31'd0, sat_o, result_o}, 64'd0);
    rst_i = 1'b0;
    tick();

    bq = {32'h0001_0000, 32'h0001_8000, 32'h8000_4000};
    run_sum(0, 1'b0);
    run_sum(2, 1'b1);
    bq = {32'h7FFF_FFFF, 32'h7FFF_FFFF};
    run_sum(0, 1'b0);
    bq = {32'hFFFF_FFFF, 32'hFFFF_FFFF};
    run_sum(0, 1'b0);
    bq = {32'h0001_0000, 32'h8001_0000};
    run_sum(0, 1'b0);
    bq = {32'h8000_0000, 32'h8001_0000};
    run_sum(0, 1'b0);
    bq = {};
    run_sum(0, 1'b0);
    bq = {32'h0003_0000, 32'h8000_8000, 32'h0000_0001};
    run_sum(3, 1'b1);

    // Abort after one of three beats: outputs clear at once, no done follows.
    dc = done_count;
    start_i = 1'b1;
    len_i   = 16'd3;
    tick();
    start_i = 1'b0;
    valid_i = 1'b1;
    data_i  = 32'h0001_0000;
    tick();
    valid_i = 1'b0;
    rst_i   = 1'b1;
    #1;
    check("abort_result", {31'd0, sat_o, result_o}, 64'd0);
    check("abort_busy", {63'd0, busy_o}, 64'd0);
    check("abort_done", {63'd0, done_o}, 64'd0);
    tick();
    rst_i = 1'b0;
    repeat (3) tick();
    check("abort_no_done", 64'(done_count), 64'(dc));
    check("abort_idle", {63'd0, busy_o}, 64'd0);
    bq = {32'h0002_0000};
    run_sum(0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      int len = $urandom_range(6);
      bq = {};
      for (int i = 0; i < len; i++) bq.push_back(rand_beat());
      run_sum($urandom_range(2), $urandom_range(1) == 1);
    end

    repeat (3) tick();
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
